// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: reset PC, NOP
// encoding, instruction field positions and fetch FSM encodings.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TGT_MSB    = 25;
  localparam int TGT_LSB    = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load has priority over clear; otherwise the
// contents hold. Decode fields are plain slices of the registered word.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o,
  output logic [25:0] target26_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] instr_q;

  // Clearing drops only the valid bit; the stale word is harmless once invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      pc4_q   <= 32'h0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      pc4_q   <= pc_i + 32'd4;
      instr_q <= instr_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc4_o      = pc4_q;
  assign instr_o    = instr_q;
  assign opcode_o   = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign rs_o       = instr_q[RS_MSB:RS_LSB];
  assign rt_o       = instr_q[RT_MSB:RT_LSB];
  assign rd_o       = instr_q[RD_MSB:RD_LSB];
  assign funct_o    = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign imm16_o    = instr_q[IMM_MSB:IMM_LSB];
  assign target26_o = instr_q[TGT_MSB:TGT_LSB];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding req/ack fetch FSM, one-word
// skid buffer for decode stalls, and the IF/ID register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         id_stall,
  output logic         id_valid,
  output logic [31:0]  id_pc,
  output logic [31:0]  id_pc4,
  output logic [31:0]  id_instr,
  output logic [5:0]   id_opcode,
  output logic [4:0]   id_rs,
  output logic [4:0]   id_rt,
  output logic [4:0]   id_rd,
  output logic [5:0]   id_funct,
  output logic [15:0]  id_imm16,
  output logic [25:0]  id_target26,
  output fetch_state_e dbg_state
);

  // Handshake: imem_req/imem_addr come from registered state only, so they
  // stay stable until the cycle imem_ack is seen high; one request at a time.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc_q, skid_pc_d;

  logic         ifid_load;
  logic         ifid_clear;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;
  logic         if_free;

  assign if_free = !id_valid || !id_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_load    = 1'b0;
    ifid_instr   = imem_rdata;
    ifid_pc      = pc_q;
    // Redirect flushes IF/ID; otherwise a consumed entry empties unless refilled.
    ifid_clear   = redirect_valid || !id_stall;

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d         = word_align(redirect_pc);
          drain_addr_d = pc_q;
          state_d      = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          pc_d = pc_q + 32'd4;
          if (if_free) begin
            ifid_load = 1'b1;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = word_align(redirect_pc);
          state_d = FETCH;
        end else if (!id_stall) begin
          ifid_load    = 1'b1;
          ifid_instr   = skid_instr_q;
          ifid_pc      = skid_pc_q;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        // A new redirect while draining only retargets pc; the stale
        // request itself must still complete before fetching resumes.
        if (redirect_valid) begin
          pc_d = word_align(redirect_pc);
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imem_req  = rst_n && (state_q != HOLD);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign dbg_state = state_q;

  fetch_stage_if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ifid_load),
    .clear_i    (ifid_clear),
    .instr_i    (ifid_instr),
    .pc_i       (ifid_pc),
    .valid_o    (id_valid),
    .pc_o       (id_pc),
    .pc4_o      (id_pc4),
    .instr_o    (id_instr),
    .opcode_o   (id_opcode),
    .rs_o       (id_rs),
    .rt_o       (id_rt),
    .rd_o       (id_rd),
    .funct_o    (id_funct),
    .imm16_o    (id_imm16),
    .target26_o (id_target26)
  );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the multi-cycle/pipelined MIPS core.
- Holds the PC and runs a req/ack handshake to instruction memory.
- Buffers one returned word across decode stalls and drives the IF/ID register.
- Decoded fields feed decode; id_imm16 goes directly to the 16-to-32 sign extender.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset; must be word-aligned.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, word-aligned
imem_ack  input  1  memory response; imem_rdata valid this cycle
imem_rdata  input  32  instruction word
redirect_valid  input  1  branch/jump taken; one-cycle pulse
redirect_pc  input  32  redirect target
id_stall  input  1  decode cannot accept a new instruction
id_valid  output  1  IF/ID holds a live instruction
id_pc  output  32  PC of id_instr
id_pc4  output  32  id_pc + 4
id_instr  output  32  instruction word
id_opcode  output  6  id_instr[31:26]
id_rs  output  5  id_instr[25:21]
id_rt  output  5  id_instr[20:16]
id_rd  output  5  id_instr[15:11]
id_funct  output  6  id_instr[5:0]
id_imm16  output  16  id_instr[15:0], to sign extender
id_target26  output  26  id_instr[25:0], jump target

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values:
  - pc = RESET_PC; state = FETCH.
  - id_valid = 0; id_instr = 32'h0 (NOP); id_pc = 0; id_pc4 = 0; all field outputs = 0.
  - skid buffer empty.
  - imem_req = 0 while rst_n is low.
- Handshake:
  - imem_req may rise at any time.
  - Once raised, imem_req and imem_addr stay stable until the cycle imem_ack = 1.
  - Zero-wait ack (same cycle as req) is legal.
  - Exactly one request is outstanding at a time.
- States:
  - FETCH: imem_req = 1, imem_addr = pc.
    - On ack with no redirect: if IF/ID is free (id_valid = 0 or id_stall = 0), load IF/ID with {rdata, pc, pc+4}, set id_valid = 1, pc <= pc+4, stay in FETCH.
    - If IF/ID is blocked (id_valid = 1 and id_stall = 1), write {rdata, pc} to the skid buffer, pc <= pc+4, go to HOLD.
    - If IF/ID is consumed (id_stall = 0) and there is no ack, id_valid <= 0.
  - HOLD: imem_req = 0. When id_stall = 0, move skid to IF/ID (id_valid = 1), clear skid, go to FETCH. Requesting resumes the following cycle.
  - DRAIN: imem_req = 1, imem_addr = the stale address latched at redirect. On ack, discard rdata and go to FETCH. The next request uses pc.
- Redirect (highest priority, overrides id_stall):
  - pc <= {redirect_pc[31:2], 2'b00}, forcing the low bits to zero.
  - id_valid <= 0; skid cleared.
  - From FETCH without ack in the same cycle: go to DRAIN.
  - From FETCH with ack in the same cycle: discard rdata, go to FETCH.
  - From HOLD: go to FETCH.
  - From DRAIN: stay in DRAIN; pc takes the new target.
- Latency: instruction appears on id_* the cycle after ack (registered). With zero-wait memory and no stalls, throughput is one instruction per cycle.
- Arithmetic: pc + 4 is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0.
- Field outputs: pure slices of the registered id_instr; no extra latency.
- Reset mid-operation: every state, including DRAIN and HOLD, returns to reset values immediately. The outstanding memory transaction is abandoned.

Decomposition:
- Shared header mips_defs.vh holds:
  - RESET_PC default;
  - NOP encoding 32'h0000_0000;
  - instruction field bit positions;
  - FSM encodings FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with load, flush and hold, plus field slicing.
- FSM, PC and skid buffer stay in fetch_stage.

Test Plan:
1. Reset release, zero-wait ack, no stall -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles. id_valid rises the cycle after the first ack. id_pc/id_instr track each word. Word 0x2008FFFF gives id_imm16 = 0xFFFF and id_rt = 8.
2. Ack delayed 3 cycles -> imem_req and imem_addr = 0x3000 held stable all 3 cycles; id_valid = 0 until the cycle after ack.
3. id_stall = 1 for 4 cycles while IF/ID is full and an ack arrives -> skid captures the word and imem_req = 0 during HOLD. IF/ID unchanged during the stall. The word appears the cycle after stall release; no instruction lost or duplicated.
4. redirect_pc = 0x3100 while a request for 0x3010 is pending -> id_valid = 0 next cycle; req held at 0x3010 until ack; that data is dropped; next request addr = 0x3100.
5. Redirect with simultaneous ack and id_stall = 1, redirect_pc = 0x3103 -> flush wins, the acked data is discarded, next imem_addr = 0x3100.
6. Redirect to 0xFFFF_FFFC, then ack -> next imem_addr = 0x0000_0000. Separately, assert rst_n = 0 mid-DRAIN -> outputs go to reset values immediately; after release the first request is to 0x3000.
